// File: rtl/fifo_rd_fwft_stage.sv
// Read-side output stage of the async FIFO (rclk domain).
// Turns the FIFO's r_en/empty/registered-rdata interface into a
// first-word-fall-through valid/ready stream. A 3-entry skid buffer hides the
// one-cycle memory read latency so the stage sustains one word per cycle.
// r_en and m_valid are flops whose next state is computed here, so m_ready
// never reaches r_en combinationally.
module fifo_rd_fwft_stage #(
   parameter int DATA_WIDTH = 8
) (
   input  logic                  rclk,
   input  logic                  rrst_n,
   input  logic                  empty,
   output logic                  r_en,
   input  logic [DATA_WIDTH-1:0] rdata,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic [DATA_WIDTH-1:0] m_data,
   output logic [1:0]            buf_cnt
);

   // Advance a skid-buffer index modulo 3 (2 wraps to 0).
   function automatic logic [1:0] idx_inc(input logic [1:0] idx);
      logic [1:0] nxt;
      case (idx)
         2'd0:    nxt = 2'd1;
         2'd1:    nxt = 2'd2;
         default: nxt = 2'd0;
      endcase
      return nxt;
   endfunction

   logic [DATA_WIDTH-1:0] mem_r [0:2];
   logic                  pend_r;
   logic [1:0]            cnt_r;
   logic [1:0]            wr_idx_r;
   logic [1:0]            rd_idx_r;
   logic                  valid_r;
   logic                  ren_r;

   logic                  accept_s;
   logic                  push_s;
   logic                  pop_s;
   logic [1:0]            cnt_nxt_s;
   logic                  ren_nxt_s;
   logic                  valid_nxt_s;
   logic [DATA_WIDTH-1:0] head_s;

   // Handshake decode and next-state values for count, r_en and m_valid.
   always_comb begin
      accept_s  = ren_r & ~empty;
      push_s    = pend_r;
      pop_s     = valid_r & m_ready;
      cnt_nxt_s = cnt_r;
      case ({push_s, pop_s})
         2'b10:   cnt_nxt_s = cnt_r + 2'd1;
         2'b01:   cnt_nxt_s = cnt_r - 2'd1;
         default: cnt_nxt_s = cnt_r;
      endcase
      // Next r_en sees next count plus the word that the current accept puts in flight.
      ren_nxt_s   = (({1'b0, cnt_nxt_s}) + ({2'b00, accept_s})) < 3'd3;
      valid_nxt_s = (cnt_nxt_s != 2'd0);
   end

   // Control state: in-flight flag, occupancy, indices and registered outputs.
   always_ff @(posedge rclk or negedge rrst_n) begin
      if (!rrst_n) begin
         pend_r   <= 1'b0;
         cnt_r    <= 2'd0;
         wr_idx_r <= 2'd0;
         rd_idx_r <= 2'd0;
         valid_r  <= 1'b0;
         ren_r    <= 1'b1;
      end else begin
         pend_r  <= accept_s;
         cnt_r   <= cnt_nxt_s;
         valid_r <= valid_nxt_s;
         ren_r   <= ren_nxt_s;
         if (push_s) begin
            wr_idx_r <= idx_inc(wr_idx_r);
         end else begin
            wr_idx_r <= wr_idx_r;
         end
         if (pop_s) begin
            rd_idx_r <= idx_inc(rd_idx_r);
         end else begin
            rd_idx_r <= rd_idx_r;
         end
      end
   end

   // Skid-buffer storage; contents are meaningless until counted, so no reset.
   always_ff @(posedge rclk) begin
      if (push_s) begin
         mem_r[wr_idx_r] <= rdata;
      end
   end

   // Head-of-buffer select.
   always_comb begin
      head_s = mem_r[0];
      case (rd_idx_r)
         2'd0:    head_s = mem_r[0];
         2'd1:    head_s = mem_r[1];
         default: head_s = mem_r[2];
      endcase
   end

   assign r_en    = ren_r;
   assign m_valid = valid_r;
   assign m_data  = head_s;
   assign buf_cnt = cnt_r;

endmodule

// File: tb/tb_fifo_rd_fwft_stage.sv
// Self-checking bench for fifo_rd_fwft_stage: the FIFO source and the skid
// buffer are modelled as queues; words land in the buffer two cycles after
// their accept and leave in order on every valid/ready handshake.
module tb_fifo_rd_fwft_stage;

   logic       rclk    = 1'b0;
   logic       rrst_n  = 1'b0;
   logic       empty   = 1'b1;
   logic       r_en;
   logic [7:0] rdata   = 8'h00;
   logic       m_valid;
   logic       m_ready = 1'b1;
   logic [7:0] m_data;
   logic [1:0] buf_cnt;

   fifo_rd_fwft_stage #(.DATA_WIDTH(8)) dut (
      .rclk    (rclk),
      .rrst_n  (rrst_n),
      .empty   (empty),
      .r_en    (r_en),
      .rdata   (rdata),
      .m_valid (m_valid),
      .m_ready (m_ready),
      .m_data  (m_data),
      .buf_cnt (buf_cnt)
   );

   always #5 rclk = ~rclk;

   int         n_tests = 0;
   int         n_fail  = 0;
   logic [7:0] src_q[$];
   logic [7:0] exp_q[$];
   bit         inflight = 1'b0;
   logic [7:0] inflight_data = 8'h00;
   int         gap_pct = 0;
   int         rdy_pct = 100;
   int         delivered = 0;
   int         cur_run = 0;
   int         max_run = 0;
   bit         prev_stall = 1'b0;
   logic [7:0] prev_data = 8'h00;
   bit         saw_full = 1'b0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic refill_inputs();
      empty   = (!rrst_n) || (src_q.size() == 0) || (int'($urandom_range(99)) < gap_pct);
      m_ready = (int'($urandom_range(99)) < rdy_pct);
   endtask

   // One rclk cycle: check outputs on the falling edge, then advance the model.
   task automatic cycle();
      bit exp_valid;
      bit exp_ren;
      bit acc;
      bit pop;
      @(negedge rclk);
      exp_valid = (exp_q.size() != 0);
      exp_ren   = ((exp_q.size() + int'(inflight)) < 3);
      check_eq("m_valid", 32'(m_valid), 32'(exp_valid));
      check_eq("buf_cnt", 32'(buf_cnt), 32'(exp_q.size()));
      check_eq("r_en", 32'(r_en), 32'(exp_ren));
      check_eq("no_overflow", 32'((int'(buf_cnt) + int'(inflight)) <= 3), 32'd1);
      if (exp_valid) check_eq("m_data", 32'(m_data), 32'(exp_q[0]));
      if (prev_stall) check_eq("stall_stable", 32'(m_data), 32'(prev_data));
      prev_stall = m_valid & ~m_ready;
      prev_data  = m_data;
      if (m_valid) cur_run++; else cur_run = 0;
      if (cur_run > max_run) max_run = cur_run;
      if (buf_cnt == 2'd3 && !r_en) saw_full = 1'b1;
      acc = exp_ren && !empty;
      pop = exp_valid && m_ready;
      @(posedge rclk);
      #1;
      if (pop) begin
         void'(exp_q.pop_front());
         delivered++;
      end
      if (inflight) exp_q.push_back(inflight_data);
      inflight = acc;
      if (acc) begin
         inflight_data = src_q.pop_front();
         rdata = inflight_data;
      end else begin
         rdata = 8'($urandom);
      end
      refill_inputs();
   endtask

   task automatic apply_reset_now();
      rrst_n = 1'b0;
      #1;
      check_eq("rst_m_valid", 32'(m_valid), 32'd0);
      check_eq("rst_buf_cnt", 32'(buf_cnt), 32'd0);
      check_eq("rst_r_en", 32'(r_en), 32'd1);
      exp_q.delete();
      src_q.delete();
      inflight   = 1'b0;
      prev_stall = 1'b0;
      empty      = 1'b1;
   endtask

   initial begin
      int d0;
      // 1: reset then idle with an empty FIFO
      gap_pct = 0;
      rdy_pct = 100;
      repeat (3) cycle();
      rrst_n = 1'b1;
      repeat (10) cycle();

      // 2: single word
      d0 = delivered;
      src_q.push_back(8'hA5);
      refill_inputs();
      repeat (6) cycle();
      check_eq("single_delivered", 32'(delivered - d0), 32'd1);

      // 3: 16-word burst at full rate
      for (int i = 0; i < 16; i++) src_q.push_back(8'(i));
      refill_inputs();
      cur_run = 0;
      max_run = 0;
      repeat (24) cycle();
      check_eq("burst_run", 32'(max_run), 32'd16);

      // 4: burst into a stalled consumer, then drain
      rdy_pct = 0;
      for (int i = 0; i < 8; i++) src_q.push_back(8'h40 + 8'(i));
      refill_inputs();
      saw_full = 1'b0;
      repeat (8) cycle();
      check_eq("stall_full", 32'(saw_full), 32'd1);
      rdy_pct = 100;
      refill_inputs();
      repeat (16) cycle();
      check_eq("stall_drained", 32'(src_q.size() + exp_q.size()), 32'd0);

      // 5: random gaps and backpressure, 1000 words
      for (int i = 0; i < 1000; i++) src_q.push_back(8'($urandom));
      gap_pct = 30;
      rdy_pct = 50;
      refill_inputs();
      for (int k = 0; k < 20000 && (src_q.size() != 0 || exp_q.size() != 0 || inflight); k++) cycle();
      check_eq("random_drained", 32'(src_q.size() + exp_q.size() + int'(inflight)), 32'd0);

      // 6: asynchronous reset with two buffered words and one in flight
      gap_pct = 0;
      rdy_pct = 0;
      for (int i = 0; i < 6; i++) src_q.push_back(8'h90 + 8'(i));
      refill_inputs();
      for (int k = 0; k < 20 && !(exp_q.size() == 2 && inflight); k++) cycle();
      check_eq("pre_reset_state", 32'(exp_q.size() == 2 && inflight), 32'd1);
      #2;
      apply_reset_now();
      repeat (3) cycle();
      rrst_n  = 1'b1;
      rdy_pct = 100;
      d0 = delivered;
      for (int i = 0; i < 4; i++) src_q.push_back(8'hC0 + 8'(i));
      refill_inputs();
      repeat (10) cycle();
      check_eq("post_reset_words", 32'(delivered - d0), 32'd4);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
